// File: rtl/wb_sram_slave_if.sv
// wb_sram_slave_if: 8-bit Wishbone memory bus between the CPU master and the SRAM slave
//  adr   master->slave  ADDR_W  address
//  tga   master->slave  2       address tag (00 = MEM, 01 = IO)
//  wdat  master->slave  8       write data
//  rdat  slave->master  8       read data
//  cyc   master->slave  1       bus cycle
//  stb   master->slave  1       strobe
//  we    master->slave  1       1 = write
//  ack   slave->master  1       acknowledge
interface wb_sram_slave_if #(parameter int ADDR_W = 16);
    logic [ADDR_W-1:0] adr;
    logic [1:0]        tga;
    logic [7:0]        wdat;
    logic [7:0]        rdat;
    logic              cyc;
    logic              stb;
    logic              we;
    logic              ack;
    modport master (output adr, tga, wdat, cyc, stb, we, input rdat, ack);
    modport slave  (input adr, tga, wdat, cyc, stb, we, output rdat, ack);
endinterface

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone slave turning tagged MEM cycles into timed async SRAM accesses
//  clk_i, rst_i        clock, synchronous active-high reset
//  bus                 Wishbone slave modport (adr, tga, wdat, cyc, stb, we in; rdat, ack out)
//  bank_i              bank bits prepended to the SRAM address, sampled at accept
//  sram_adr_o          {bank, adr}
//  sram_dq_o/_oe_o     write data and its pin-drive enable; tristate lives at top level
//  sram_dq_i           read data from the SRAM
//  sram_ce/oe/we_n_o   active-low SRAM strobes
//  wp_i                write protect, present only when SRAM_WPROT_EN is defined
module wb_sram_slave #(
    parameter int ADDR_W      = 16,
    parameter int BANK_W      = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    wb_sram_slave_if.slave           bus,
    input  logic [BANK_W-1:0]        bank_i,
`ifdef SRAM_WPROT_EN
    input  logic                     wp_i,
`endif
    output logic [BANK_W+ADDR_W-1:0] sram_adr_o,
    output logic [7:0]               sram_dq_o,
    output logic                     sram_dq_oe_o,
    input  logic [7:0]               sram_dq_i,
    output logic                     sram_ce_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_we_n_o
);
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("wb_sram_slave: WAIT_CYCLES must be in 1..15");
    end
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] ACK    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    logic [2:0] state;
    logic [3:0] cnt;
    logic       we_q;
    logic       wr_q;
    logic       ack_q;
    logic [7:0] rdat_q;
    logic       req;
    logic       live;
    logic       wr_ok;
`ifdef SRAM_WPROT_EN
    assign wr_ok = ~wp_i;
`else
    assign wr_ok = 1'b1;
`endif
    assign req      = bus.cyc & bus.stb & (bus.tga == 2'b00);
    assign live     = bus.cyc & bus.stb;
    assign bus.ack  = ack_q;
    assign bus.rdat = rdat_q;
    // we_q selects read vs write timing; wr_q says whether the SRAM pins are actually driven,
    // so a protected write keeps the normal handshake without touching the array
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            wr_q         <= 1'b0;
            ack_q        <= 1'b0;
            rdat_q       <= 8'h00;
            sram_adr_o   <= '0;
            sram_dq_o    <= 8'h00;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state        <= SETUP;
                    sram_adr_o   <= {bank_i, bus.adr};
                    sram_dq_o    <= bus.wdat;
                    we_q         <= bus.we;
                    wr_q         <= bus.we & wr_ok;
                    sram_dq_oe_o <= bus.we & wr_ok;
                    sram_ce_n_o  <= 1'b0;
                end
                SETUP, ACCESS: if (!live) begin
                    state        <= IDLE;
                    sram_ce_n_o  <= 1'b1;
                    sram_oe_n_o  <= 1'b1;
                    sram_we_n_o  <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                end else if (state == SETUP) begin
                    state       <= ACCESS;
                    cnt         <= 4'(WAIT_CYCLES - 1);
                    sram_oe_n_o <= we_q;
                    sram_we_n_o <= ~wr_q;
                end else if (cnt == 4'd0) begin
                    state       <= ACK;
                    ack_q       <= 1'b1;
                    sram_oe_n_o <= 1'b1;
                    sram_we_n_o <= 1'b1;
                    rdat_q      <= we_q ? rdat_q : sram_dq_i;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                // ce_n and dq_oe were held through ACK for data hold time
                ACK: begin
                    state        <= DONE;
                    sram_ce_n_o  <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                end
                DONE: state <= bus.stb ? DONE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed self-checking bench for wb_sram_slave with a behavioural SRAM
module tb_wb_sram_slave;
    localparam int AW = 16;
    localparam int BW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wb_sram_slave_if #(.ADDR_W(AW)) bus ();
    logic [BW-1:0]    bank = '0;
    logic [BW+AW-1:0] sram_adr;
    logic [7:0]       sram_dq_o;
    logic [7:0]       sram_dq_i;
    logic             dq_oe, ce_n, oe_n, we_n;
`ifdef SRAM_WPROT_EN
    logic wp = 1'b0;
`endif
    wb_sram_slave #(.ADDR_W(AW), .BANK_W(BW), .WAIT_CYCLES(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .bank_i(bank),
`ifdef SRAM_WPROT_EN
        .wp_i(wp),
`endif
        .sram_adr_o(sram_adr),
        .sram_dq_o(sram_dq_o),
        .sram_dq_oe_o(dq_oe),
        .sram_dq_i(sram_dq_i),
        .sram_ce_n_o(ce_n),
        .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n)
    );
    logic [7:0]       mem [0:(1<<(BW+AW))-1];
    logic             pl_en = 1'b0;
    logic [BW+AW-1:0] pl_adr = '0;
    logic [7:0]       pl_dat = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_adr] <= pl_dat;
        else if (!ce_n && !we_n && dq_oe) mem[sram_adr] <= sram_dq_o;
    end
    assign sram_dq_i = (!ce_n && !oe_n) ? mem[sram_adr] : 8'h00;
    int oe_low = 0, we_low = 0, we_bad = 0, ack_hi = 0, ce_low = 0;
    always @(negedge clk) begin
        oe_low += int'(!oe_n);
        we_low += int'(!we_n);
        we_bad += int'(!we_n && !dq_oe);
        ack_hi += int'(bus.ack);
        ce_low += int'(!ce_n);
    end
    int errors = 0;
    int checks = 0;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic preload(input logic [BW+AW-1:0] a, input logic [7:0] d);
        pl_adr = a;
        pl_dat = d;
        pl_en  = 1'b1;
        tick();
        pl_en  = 1'b0;
    endtask
    task automatic start(input logic w, input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [7:0] d);
        bank     = b;
        bus.adr  = a;
        bus.we   = w;
        bus.wdat = d;
        bus.tga  = 2'b00;
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
    endtask
    task automatic wait_ack(output int n);
        n = 0;
        while (!bus.ack && n < 20) begin
            tick();
            n++;
        end
    endtask
    task automatic stop();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        tick();
        tick();
    endtask
    int lat, o0, w0, b0, a0, c0;
    initial begin
        bus.adr = '0; bus.tga = 2'b00; bus.wdat = '0; bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_dat", 32'(bus.rdat), 32'h00);
        chk("rst_ce", 32'(ce_n), 32'h1);
        chk("rst_oe", 32'(oe_n), 32'h1);
        chk("rst_we", 32'(we_n), 32'h1);
        chk("rst_dqoe", 32'(dq_oe), 32'h0);
        chk("rst_adr", 32'(sram_adr), 32'h0);
        chk("rst_dq", 32'(sram_dq_o), 32'h0);
        rst = 1'b0;
        preload(19'h31234, 8'hA5);
        // 1: read with wait states
        o0 = oe_low; a0 = ack_hi;
        start(1'b0, 3'd3, 16'h1234, 8'h00);
        tick();
        chk("t1_setup_ce", 32'(ce_n), 32'h0);
        chk("t1_setup_oe", 32'(oe_n), 32'h1);
        chk("t1_adr", 32'(sram_adr), 32'h31234);
        tick();
        chk("t1_access_oe", 32'(oe_n), 32'h0);
        wait_ack(lat);
        chk("t1_latency", 32'(lat + 2), 32'd4);
        chk("t1_dat", 32'(bus.rdat), 32'hA5);
        stop();
        chk("t1_oe_cycles", 32'(oe_low - o0), 32'd2);
        chk("t1_acks", 32'(ack_hi - a0), 32'd1);
        // 2: write then readback
        w0 = we_low; b0 = we_bad; a0 = ack_hi;
        start(1'b1, 3'd0, 16'h0042, 8'h5C);
        tick();
        chk("t2_setup_dqoe", 32'(dq_oe), 32'h1);
        chk("t2_setup_we", 32'(we_n), 32'h1);
        tick();
        chk("t2_access_we", 32'(we_n), 32'h0);
        chk("t2_dq", 32'(sram_dq_o), 32'h5C);
        wait_ack(lat);
        chk("t2_latency", 32'(lat + 2), 32'd4);
        stop();
        chk("t2_we_cycles", 32'(we_low - w0), 32'd2);
        chk("t2_we_no_drive", 32'(we_bad - b0), 32'd0);
        chk("t2_acks", 32'(ack_hi - a0), 32'd1);
        chk("t2_dat_kept", 32'(bus.rdat), 32'hA5);
        start(1'b0, 3'd0, 16'h0042, 8'h00);
        wait_ack(lat);
        chk("t2_rb_latency", 32'(lat), 32'd4);
        chk("t2_readback", 32'(bus.rdat), 32'h5C);
        stop();
        // 3: strobe held after ack
        o0 = oe_low; a0 = ack_hi;
        start(1'b0, 3'd3, 16'h1234, 8'h00);
        wait_ack(lat);
        chk("t3_latency", 32'(lat), 32'd4);
        repeat (6) tick();
        chk("t3_one_oe", 32'(oe_low - o0), 32'd2);
        chk("t3_one_ack", 32'(ack_hi - a0), 32'd1);
        chk("t3_idle_ce", 32'(ce_n), 32'h1);
        bus.stb = 1'b0;
        tick();
        bus.stb = 1'b1;
        tick();
        chk("t3_second_accept", 32'(ce_n), 32'h0);
        wait_ack(lat);
        chk("t3_second_latency", 32'(lat + 1), 32'd4);
        stop();
        chk("t3_total_acks", 32'(ack_hi - a0), 32'd2);
        // 4: abort in the first ACCESS cycle
        a0 = ack_hi;
        start(1'b0, 3'd3, 16'h1234, 8'h00);
        tick();
        tick();
        chk("t4_access_oe", 32'(oe_n), 32'h0);
        bus.stb = 1'b0;
        tick();
        chk("t4_abort_ce", 32'(ce_n), 32'h1);
        chk("t4_abort_oe", 32'(oe_n), 32'h1);
        chk("t4_abort_we", 32'(we_n), 32'h1);
        chk("t4_abort_dqoe", 32'(dq_oe), 32'h0);
        stop();
        chk("t4_no_ack", 32'(ack_hi - a0), 32'd0);
        start(1'b0, 3'd0, 16'h0042, 8'h00);
        wait_ack(lat);
        chk("t4_next_latency", 32'(lat), 32'd4);
        chk("t4_next_dat", 32'(bus.rdat), 32'h5C);
        stop();
        // 5: IO-tagged cycles are ignored
        a0 = ack_hi; c0 = ce_low;
        start(1'b0, 3'd3, 16'h1234, 8'h00);
        bus.tga = 2'b01;
        repeat (10) tick();
        chk("t5_no_ack", 32'(ack_hi - a0), 32'd0);
        chk("t5_no_ce", 32'(ce_low - c0), 32'd0);
        stop();
        bus.tga = 2'b00;
        // 6: reset mid-ACCESS
        a0 = ack_hi;
        start(1'b1, 3'd5, 16'hBEEF, 8'h77);
        tick();
        tick();
        chk("t6_access_we", 32'(we_n), 32'h0);
        rst = 1'b1;
        tick();
        chk("t6_rst_ce", 32'(ce_n), 32'h1);
        chk("t6_rst_we", 32'(we_n), 32'h1);
        chk("t6_rst_oe", 32'(oe_n), 32'h1);
        chk("t6_rst_dqoe", 32'(dq_oe), 32'h0);
        chk("t6_rst_adr", 32'(sram_adr), 32'h0);
        chk("t6_rst_dat", 32'(bus.rdat), 32'h00);
        rst = 1'b0;
        stop();
        chk("t6_rst_no_ack", 32'(ack_hi - a0), 32'd0);
`ifdef SRAM_WPROT_EN
        start(1'b1, 3'd1, 16'h0077, 8'h11);
        wait_ack(lat);
        stop();
        w0 = we_low; a0 = ack_hi;
        wp = 1'b1;
        start(1'b1, 3'd1, 16'h0077, 8'hFF);
        tick();
        chk("wp_setup_dqoe", 32'(dq_oe), 32'h0);
        wait_ack(lat);
        chk("wp_latency", 32'(lat + 1), 32'd4);
        stop();
        wp = 1'b0;
        chk("wp_we_never", 32'(we_low - w0), 32'd0);
        chk("wp_acked", 32'(ack_hi - a0), 32'd1);
        start(1'b0, 3'd1, 16'h0077, 8'h00);
        wait_ack(lat);
        chk("wp_readback", 32'(bus.rdat), 32'h11);
        stop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
